later_data_fetcher: RTL and testbench

//  Downstream reader of the later data spad: given a column start address, walks the spad column,

---
 rtl/later_data_fetcher_pkg.sv | 46 ++++
 rtl/later_data_fetcher_if.sv | 35 +++
 rtl/later_data_fetcher_skid_fifo.sv | 49 ++++
 rtl/later_data_fetcher.sv | 114 +++++++++++
 tb/tb_later_data_fetcher.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/later_data_fetcher_pkg.sv
// Shared PE definitions for the later-data spad reader: word layout, terminator, beat format.
// Ports: none (package). Imported by the fetcher, its interface and the testbench-facing types.
// The beat struct is the unit stored in the output skid FIFO and presented to the MAC stage.
package later_data_fetcher_pkg;

   localparam int ADDR_W      = 7;
   localparam int SPAD_WORD_W = 12;
   localparam int DATA_W      = 8;
   localparam int CNT_W       = 4;
   localparam int MAX_ENTRIES = 1 << CNT_W;

   // Field slice positions inside a spad word
   localparam int DATA_MSB = 11;
   localparam int DATA_LSB = 4;
   localparam int CNT_MSB  = 3;
   localparam int CNT_LSB  = 0;

   localparam logic [SPAD_WORD_W-1:0] TERMINATOR = 12'h000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
      logic [CNT_W-1:0]  count;
   } beat_t;

   localparam int BEAT_W = $bits(beat_t);

   localparam beat_t LAST_BEAT = '{last: 1'b1, data: '0, count: '0};

   // Plain field split; the data byte is passed through unsigned-extended (no sign handling here).
   function automatic beat_t word_to_beat(input logic [SPAD_WORD_W-1:0] w);
      beat_t b;
      b.last  = 1'b0;
      b.data  = w[DATA_MSB:DATA_LSB];
      b.count = w[CNT_MSB:CNT_LSB];
      return b;
   endfunction

endpackage

// File: rtl/later_data_fetcher_if.sv
// Bundle of the fetcher's start, flush, spad-side and MAC-side signals.
// Ports: none; modport slave is the fetcher's view, modport master the surrounding logic's view.
// Clock and reset stay outside the bundle as plain ports.
interface later_data_fetcher_if;
   import later_data_fetcher_pkg::*;

   logic                   start_valid;
   logic                   start_ready;
   logic [ADDR_W-1:0]      start_idx;
   logic                   flush;
   logic [ADDR_W-1:0]      spad_read_idx;
   logic                   spad_read_idx_en;
   logic                   spad_read_en;
   logic                   spad_index_inc;
   logic [SPAD_WORD_W-1:0] spad_data_out;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_W-1:0]      out_data;
   logic [CNT_W-1:0]       out_count;
   logic                   out_last;
   logic                   overrun;

   modport slave (
      input  start_valid, start_idx, flush, spad_data_out, out_ready,
      output start_ready, spad_read_idx, spad_read_idx_en, spad_read_en, spad_index_inc,
             out_valid, out_data, out_count, out_last, overrun
   );

   modport master (
      output start_valid, start_idx, flush, spad_data_out, out_ready,
      input  start_ready, spad_read_idx, spad_read_idx_en, spad_read_en, spad_index_inc,
             out_valid, out_data, out_count, out_last, overrun
   );

endinterface

// File: rtl/later_data_fetcher_skid_fifo.sv
// Two-entry beat FIFO between the spad return path and the MAC handshake.
// Ports: clock/reset, clear (drop contents), push/push_dat, pop/head_dat, occupancy, empty.
// Head is registered storage, so it stays stable while not popped; push into a full FIFO is dropped.
module fetch_skid_fifo #(
   parameter int WIDTH = 13
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic [1:0]       occupancy,
   output logic             empty
);
   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (occupancy == 2'd0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (occupancy != 2'd2);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         occupancy <= 2'd0;
      end else if (clear) begin
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         occupancy <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         occupancy <= occupancy + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   // Storage needs no reset: reads are masked by empty at the consumer.
   always_ff @(posedge clock) begin
      if (do_push && !clear) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/later_data_fetcher.sv
// Walks one later-data spad column from a start address and streams (data, count, last) beats to the MAC.
// Ports: clock, reset (async active-low), bus (slave view: start, flush, spad control/return, beat output, overrun).
// Hides the 1-cycle BRAM latency with a 2-entry FIFO plus one in-flight read; first beat 3 cycles after start.
module later_data_fetcher
   import later_data_fetcher_pkg::*;
(
   input logic                 clock,
   input logic                 reset,
   later_data_fetcher_if.slave bus
);
   localparam logic [CNT_W:0] ENTRY_LIMIT = (CNT_W+1)'(MAX_ENTRIES);

   state_t            state;
   state_t            state_nxt;
   logic              inflight;
   logic [CNT_W:0]    entry_cnt;
   logic              overrun_q;
   logic [ADDR_W-1:0] idx_q;

   logic              start_fire;
   logic              ret_live;
   logic              ret_term;
   logic              ret_overflow;
   logic              issue;
   logic              pop;
   logic [2:0]        outstanding;
   logic [1:0]        occupancy;
   logic              fifo_empty;
   beat_t             push_beat;
   beat_t             head;
   logic [BEAT_W-1:0] head_raw;

   assign start_fire = bus.start_valid && (state == IDLE) && !bus.flush;

   // A returning word only counts in RUN; anything arriving in DRAIN is prefetch past the end.
   assign ret_live     = inflight && (state == RUN) && !bus.flush;
   assign ret_term     = ret_live && (bus.spad_data_out == TERMINATOR);
   assign ret_overflow = ret_live && !ret_term && (entry_cnt == ENTRY_LIMIT);
   assign push_beat    = (ret_term || ret_overflow) ? LAST_BEAT : word_to_beat(bus.spad_data_out);

   assign pop = !fifo_empty && bus.out_ready;

   // Outstanding words after this edge, before any new issue: a beat leaving this cycle frees
   // its slot, which is what lets a continuously-ready consumer see one beat per cycle while
   // FIFO + in-flight never exceeds two.
   assign outstanding = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
   assign issue = (state == RUN) && !bus.flush && !ret_term && !ret_overflow &&
                  (outstanding < 3'd2);

   fetch_skid_fifo #(.WIDTH(BEAT_W)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .clear     (bus.flush),
      .push      (ret_live),
      .push_dat  (push_beat),
      .pop       (pop),
      .head_dat  (head_raw),
      .occupancy (occupancy),
      .empty     (fifo_empty)
   );

   assign head = beat_t'(head_raw);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (start_fire) state_nxt = LOAD;
         LOAD:  state_nxt = RUN;
         RUN:   if (ret_term || ret_overflow) state_nxt = DRAIN;
         DRAIN: if (fifo_empty) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.flush) state_nxt = IDLE;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         inflight  <= 1'b0;
         entry_cnt <= '0;
         overrun_q <= 1'b0;
         idx_q     <= '0;
      end else begin
         inflight <= issue;
         if (start_fire) begin
            idx_q     <= bus.start_idx;
            entry_cnt <= '0;
            overrun_q <= 1'b0;
         end else begin
            if (ret_live && !ret_term && !ret_overflow) entry_cnt <= entry_cnt + 1'b1;
            if (ret_overflow) overrun_q <= 1'b1;
         end
      end
   end

   assign bus.start_ready      = (state == IDLE);
   assign bus.spad_read_idx    = idx_q;
   assign bus.spad_read_idx_en = (state == LOAD);
   assign bus.spad_read_en     = issue;
   assign bus.spad_index_inc   = issue;
   assign bus.out_valid        = !fifo_empty;
   assign bus.out_data         = fifo_empty ? '0 : head.data;
   assign bus.out_count        = fifo_empty ? '0 : head.count;
   assign bus.out_last         = !fifo_empty && head.last;
   assign bus.overrun          = overrun_q;

endmodule

// File: tb/tb_later_data_fetcher.sv
// Randomised scoreboard bench for later_data_fetcher with a behavioural spad and column model.
// Ports: none; instantiates the bus interface, a BRAM model and the fetcher.
// Stimulus pushes expected beats at start; a negedge monitor pops and compares on every transfer.
module tb_later_data_fetcher;
   import later_data_fetcher_pkg::*;

   localparam int COL_LIMIT = 16;

   typedef struct {
      logic [7:0] d;
      logic [3:0] c;
      logic       l;
   } exp_t;

   logic clock;
   logic reset;
   later_data_fetcher_if bus();

   later_data_fetcher dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   beats_seen = 0;
   int   ready_mode = 0;
   bit   hold_ready = 0;
   exp_t exp_q[$];

   logic [11:0] mem [128];
   logic [6:0]  sp_ptr = '0;
   logic [11:0] spad_q = '0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   // BRAM model: pointer load/advance, registered read one cycle after the enable.
   always @(posedge clock) begin
      if (bus.spad_read_en) spad_q <= mem[sp_ptr];
      if (bus.spad_read_idx_en) sp_ptr <= bus.spad_read_idx;
      else if (bus.spad_index_inc) sp_ptr <= sp_ptr + 7'd1;
   end
   assign bus.spad_data_out = spad_q;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d), required finish", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Consumer readiness pattern, updated shortly after every edge.
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clock);
         #2;
         case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = cyc[0];
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
         if (hold_ready) bus.out_ready = 1'b0;
      end
   end

   // Monitor: compares every transferred beat, checks stall stability and enable exclusivity.
   initial begin
      bit         prev_stall;
      logic [7:0] p_d;
      logic [3:0] p_c;
      logic       p_l;
      exp_t       e;
      prev_stall = 0;
      p_d = '0; p_c = '0; p_l = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset || bus.flush) begin
            prev_stall = 0;
            continue;
         end
         if (prev_stall) begin
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_beat", {19'd0, bus.out_data, bus.out_count, bus.out_last},
                {19'd0, p_d, p_c, p_l});
         end
         if (bus.spad_read_idx_en)
            chk("idx_en_with_read_en", {31'd0, bus.spad_read_en}, 32'd0);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_beat: got data %0h count %0h last %0b, required no beat",
                        bus.out_data, bus.out_count, bus.out_last);
            end else begin
               e = exp_q.pop_front();
               chk("beat", {19'd0, bus.out_data, bus.out_count, bus.out_last},
                   {19'd0, e.d, e.c, e.l});
            end
            beats_seen++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         p_d = bus.out_data;
         p_c = bus.out_count;
         p_l = bus.out_last;
      end
   end

   // Reference: walk the column, stop at the zero word or replace the word after 16 entries.
   task automatic expect_column(input int addr, input int max_beats, output bit ov);
      exp_t        e;
      logic [11:0] w;
      int          nb;
      ov = 0;
      nb = 0;
      for (int k = 0; k <= COL_LIMIT; k++) begin
         w = mem[(addr + k) % 128];
         if (w == 12'h000) begin
            e = '{8'h00, 4'h0, 1'b1};
         end else if (k == COL_LIMIT) begin
            e = '{8'h00, 4'h0, 1'b1};
            ov = 1;
         end else begin
            e = '{w[11:4], w[3:0], 1'b0};
         end
         if (nb < max_beats) exp_q.push_back(e);
         nb++;
         if (e.l) break;
      end
   endtask

   task automatic start_col(input int addr);
      chk("start_ready_before_start", {31'd0, bus.start_ready}, 32'd1);
      bus.start_idx   = 7'(addr);
      bus.start_valid = 1'b1;
      step();
      bus.start_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && bus.start_ready)) begin
         step();
         n++;
         if (n > 400) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: %0d beats still pending, required 0", name, exp_q.size());
            exp_q.delete();
            return;
         end
      end
   endtask

   task automatic wait_valid(input string name, output int waited);
      waited = 0;
      while (!bus.out_valid) begin
         step();
         waited++;
         if (waited > 50) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: out_valid 0, required 1", name);
            return;
         end
      end
   endtask

   initial begin
      bit ov;
      int w;
      int hs;
      int b0;
      int base;
      int len;

      for (int i = 0; i < 128; i++) mem[i] = 12'((i * 37) % 4095 + 1);
      reset           = 1'b0;
      bus.start_valid = 1'b0;
      bus.start_idx   = '0;
      bus.flush       = 1'b0;
      step();
      step();
      chk("rst_start_ready", {31'd0, bus.start_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_read_en", {30'd0, bus.spad_read_en, bus.spad_read_idx_en}, 32'd0);
      chk("rst_outputs", {19'd0, bus.out_data, bus.out_count, bus.out_last}, 32'd0);
      chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
      #3 reset = 1'b1;
      step();
      step();

      // Directed column with first-beat latency and start index checks
      mem[5] = 12'h1A3; mem[6] = 12'hFF2; mem[7] = 12'h000;
      ready_mode = 0;
      expect_column(5, 99, ov);
      start_col(5);
      hs = cyc;
      chk("load_idx_en", {31'd0, bus.spad_read_idx_en}, 32'd1);
      chk("load_idx", {25'd0, bus.spad_read_idx}, 32'd5);
      wait_valid("first_beat", w);
      chk("first_beat_latency", 32'(cyc - hs), 32'd3);
      wait_done("col5");
      chk("col5_overrun", {31'd0, bus.overrun}, {31'd0, ov});

      // Empty column: one last beat, back to IDLE two cycles after it
      mem[20] = 12'h000; mem[21] = 12'h555;
      expect_column(20, 99, ov);
      start_col(20);
      wait_valid("empty_beat", w);
      step();
      chk("empty_not_idle_yet", {31'd0, bus.start_ready}, 32'd0);
      step();
      chk("empty_idle", {31'd0, bus.start_ready}, 32'd1);
      wait_done("col20");

      // Same column under an alternating consumer
      ready_mode = 1;
      expect_column(5, 99, ov);
      start_col(5);
      wait_done("col5_toggle");

      // 18 non-zero words: 16 data beats then a forced terminator
      ready_mode = 0;
      for (int k = 0; k < 18; k++) mem[60 + k] = 12'(16 * k + 17);
      expect_column(60, 99, ov);
      chk("model_overrun_case", {31'd0, ov}, 32'd1);
      start_col(60);
      wait_done("col60");
      chk("overrun_set", {31'd0, bus.overrun}, 32'd1);

      // Flush after the second beat of a 5-entry column; overrun clears on this start
      for (int k = 0; k < 5; k++) mem[30 + k] = 12'(12'h301 + 12'(k * 16));
      mem[35] = 12'h000;
      expect_column(30, 2, ov);
      b0 = beats_seen;
      start_col(30);
      chk("overrun_cleared", {31'd0, bus.overrun}, 32'd0);
      w = 0;
      while (beats_seen < b0 + 2 && w < 50) begin
         step();
         w++;
      end
      chk("flush_two_beats", 32'(beats_seen - b0), 32'd2);
      hold_ready = 1;
      bus.flush  = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("flush_idle", {31'd0, bus.start_ready}, 32'd1);
      step();
      hold_ready = 0;
      for (int k = 0; k < 6; k++) mem[40 + k] = 12'(12'h0A0 + 12'(k * 3) + 1);
      mem[46] = 12'h000;
      expect_column(40, 99, ov);
      start_col(40);
      wait_done("col40");

      // Asynchronous reset pulse in the middle of a long column
      expect_column(60, 99, ov);
      b0 = beats_seen;
      start_col(60);
      w = 0;
      while (beats_seen < b0 + 4 && w < 50) begin
         step();
         w++;
      end
      #2 reset = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("arst_start_ready", {31'd0, bus.start_ready}, 32'd1);
      chk("arst_read_en", {30'd0, bus.spad_read_en, bus.spad_read_idx_en}, 32'd0);
      chk("arst_overrun", {31'd0, bus.overrun}, 32'd0);
      exp_q.delete();
      #3 reset = 1'b1;
      step();
      expect_column(40, 99, ov);
      start_col(40);
      wait_done("col40_after_reset");

      // Random columns, lengths 0..19, random consumer patterns
      for (int t = 0; t < 14; t++) begin
         base = $urandom_range(0, 100);
         len  = $urandom_range(0, 19);
         for (int k = 0; k < len; k++) mem[base + k] = 12'($urandom_range(1, 4095));
         if (len <= COL_LIMIT) mem[base + len] = 12'h000;
         ready_mode = $urandom_range(0, 2);
         expect_column(base, 99, ov);
         start_col(base);
         wait_done("random_col");
         chk("random_overrun", {31'd0, bus.overrun}, {31'd0, ov});
      end

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
